// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute-stage sequencer: FSM states, op-class
// encodings, wait-counter width and the latched instruction record.
package exec_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FP_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Op-class encodings on is_sorf; any code other than OP_FLOAT executes as OP_INT.
  localparam logic [1:0] OP_INT   = 2'b00;
  localparam logic [1:0] OP_FLOAT = 2'b01;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic is_float;
    logic rea;
    logic wea;
    logic branch;
    logic jump;
    logic is_jal;
    logic is_jr;
  } op_t;

  function automatic logic is_float_class(logic [1:0] sorf);
    return (sorf == OP_FLOAT) && (sorf != OP_INT);
  endfunction

  // A pure store: a load with wea set still counts as a load, and floats never store.
  function automatic logic is_store(op_t op);
    return op.wea && !op.rea && !op.is_float;
  endfunction

  function automatic logic writes_back(op_t op);
    return !(is_store(op) || op.branch || (op.jump && !op.is_jal) ||
             (op.is_jr && !op.is_jal));
  endfunction

endpackage

// File: rtl/exec_npc_sel.sv
// Combinational next-PC and link-address selection for the offered instruction.
module exec_npc_sel #(
  parameter int INST_SIZE = 10
) (
  input  logic [INST_SIZE-1:0] pc,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 is_jr,
  input  logic                 cond,
  input  logic [INST_SIZE-1:0] imm,
  input  logic [INST_SIZE-1:0] jtarget,
  input  logic [INST_SIZE-1:0] jr_addr,
  output logic [INST_SIZE-1:0] npc,
  output logic [INST_SIZE-1:0] link_pc
);

  logic [INST_SIZE-1:0] seq_pc;

  // Sums are INST_SIZE wide so address wrap-around is silent modulo 2^INST_SIZE.
  assign seq_pc  = pc + INST_SIZE'(1);
  assign link_pc = seq_pc;

  always_comb begin
    if (is_jr)                npc = jr_addr;
    else if (jump)            npc = jtarget;
    else if (branch && cond)  npc = seq_pc + imm;
    else                      npc = seq_pc;
  end

endmodule

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: accepts one decoded instruction at a time, holds it
// for float/memory latency, then retires it with next-PC and write-back strobes.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int INST_SIZE = 10,
  parameter int FP_LAT    = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INST_SIZE-1:0] pc,
  input  logic [1:0]           is_sorf,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 is_jal,
  input  logic                 is_jr,
  input  logic                 rea,
  input  logic                 wea,
  input  logic                 cond,
  input  logic [INST_SIZE-1:0] imm,
  input  logic [INST_SIZE-1:0] jtarget,
  input  logic [INST_SIZE-1:0] jr_addr,
  output logic                 alu_en,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 wb_valid,
  output logic                 wb_link,
  output logic [INST_SIZE-1:0] link_pc,
  output logic [INST_SIZE-1:0] npc,
  output logic                 npc_valid
);

  state_t               state, state_nxt;
  cnt_t                 cnt;
  op_t                  op;
  logic                 transfer;
  logic                 in_float;
  logic [INST_SIZE-1:0] npc_calc, link_calc;

  assign transfer = in_valid && in_ready;
  assign in_float = is_float_class(is_sorf);

  exec_npc_sel #(.INST_SIZE(INST_SIZE)) u_npc_sel (
    .pc      (pc),
    .branch  (branch),
    .jump    (jump),
    .is_jr   (is_jr),
    .cond    (cond),
    .imm     (imm),
    .jtarget (jtarget),
    .jr_addr (jr_addr),
    .npc     (npc_calc),
    .link_pc (link_calc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // The whole instruction, including its resolved npc, is captured at transfer
  // so the inputs are free to change while it is in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      op      <= '0;
      npc     <= '0;
      link_pc <= '0;
    end else if (transfer) begin
      cnt     <= '0;
      op      <= '{is_float: in_float, rea: rea, wea: wea, branch: branch,
                   jump: jump, is_jal: is_jal, is_jr: is_jr};
      npc     <= npc_calc;
      link_pc <= link_calc;
    end else if (state == FP_WAIT || state == MEM_WAIT) begin
      cnt     <= cnt + cnt_t'(1);
    end
  end

  // NOTE: defaulting state_nxt before the case keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          if (in_float) state_nxt = FP_WAIT;
          else if (rea) state_nxt = MEM_WAIT;
          else          state_nxt = DONE;
        end
      end
      FP_WAIT:  if (cnt == cnt_t'(FP_LAT - 1))  state_nxt = DONE;
      MEM_WAIT: if (cnt == cnt_t'(MEM_LAT - 1)) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    alu_en    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    wb_valid  = 1'b0;
    wb_link   = 1'b0;
    npc_valid = 1'b0;
    case (state)
      IDLE:     in_ready = 1'b1;
      FP_WAIT:  alu_en   = 1'b1;
      MEM_WAIT: mem_re   = (cnt == '0);
      DONE: begin
        npc_valid = 1'b1;
        mem_we    = is_store(op);
        wb_valid  = writes_back(op);
        wb_link   = op.is_jal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised and directed bench for exec_sequencer against a cycle-count model
// of each instruction's retirement trace.
module tb_exec_sequencer;

  localparam int IS   = 10;
  localparam int FPL  = 4;
  localparam int ML   = 2;
  localparam int MASK = (1 << IS) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IS-1:0] pc = '0;
  logic [1:0]    is_sorf = '0;
  logic          branch = 1'b0, jump = 1'b0, is_jal = 1'b0, is_jr = 1'b0;
  logic          rea = 1'b0, wea = 1'b0, cond = 1'b0;
  logic [IS-1:0] imm = '0, jtarget = '0, jr_addr = '0;
  logic          alu_en, mem_re, mem_we, wb_valid, wb_link, npc_valid;
  logic [IS-1:0] link_pc, npc;

  exec_sequencer #(.INST_SIZE(IS), .FP_LAT(FPL), .MEM_LAT(ML)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .is_sorf(is_sorf), .branch(branch), .jump(jump),
    .is_jal(is_jal), .is_jr(is_jr), .rea(rea), .wea(wea), .cond(cond),
    .imm(imm), .jtarget(jtarget), .jr_addr(jr_addr), .alu_en(alu_en),
    .mem_re(mem_re), .mem_we(mem_we), .wb_valid(wb_valid), .wb_link(wb_link),
    .link_pc(link_pc), .npc(npc), .npc_valid(npc_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   pc;
    bit [1:0] sorf;
    bit   branch, jump, jal, jr, rea, wea, cond;
    int   imm, jt, jra;
  } tb_op_t;

  int n_cmp = 0;
  int n_bad = 0;
  int held_npc = 0;
  int held_link = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tb_op_t int_op(int p);
    tb_op_t o;
    o = '{pc: p, sorf: 2'b00, branch: 0, jump: 0, jal: 0, jr: 0, rea: 0,
          wea: 0, cond: 0, imm: 0, jt: 0, jra: 0};
    return o;
  endfunction

  function automatic tb_op_t rand_op();
    tb_op_t o;
    o.pc = int'($urandom_range(MASK)); o.sorf = 2'($urandom);
    o.branch = 1'($urandom); o.jump = ($urandom_range(3) == 0);
    o.jal = 1'($urandom); o.jr = ($urandom_range(3) == 0);
    o.rea = 1'($urandom); o.wea = 1'($urandom); o.cond = 1'($urandom);
    o.imm = int'($urandom_range(MASK)); o.jt = int'($urandom_range(MASK));
    o.jra = int'($urandom_range(MASK));
    return o;
  endfunction

  task automatic drive(input tb_op_t o, input bit v);
    in_valid = v; pc = IS'(o.pc); is_sorf = o.sorf; branch = o.branch;
    jump = o.jump; is_jal = o.jal; is_jr = o.jr; rea = o.rea; wea = o.wea;
    cond = o.cond; imm = IS'(o.imm); jtarget = IS'(o.jt); jr_addr = IS'(o.jra);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_npc_valid"}, npc_valid, 0);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_alu_en"}, alu_en, 0);
    check({tag, "_npc_held"}, npc, held_npc);
    check({tag, "_link_held"}, link_pc, held_link);
  endtask

  // Offers o in an idle cycle and follows it to retirement. abort_at > 0 pulls
  // reset in that in-flight cycle instead of letting the op retire.
  task automatic run_op(input string tag, input tb_op_t o, input int abort_at);
    bit fl, ld, st, wb;
    int lat, enpc, elink;
    @(negedge clk);
    check_idle({tag, "_pre"});
    drive(o, 1'b1);
    fl    = (o.sorf == 2'b01);
    ld    = !fl && o.rea;
    st    = !fl && !o.rea && o.wea;
    lat   = fl ? FPL : (ld ? ML : 0);
    wb    = !(st || o.branch || (o.jump && !o.jal) || (o.jr && !o.jal));
    elink = (o.pc + 1) & MASK;
    if (o.jr)                       enpc = o.jra;
    else if (o.jump)                enpc = o.jt;
    else if (o.branch && o.cond)    enpc = (o.pc + 1 + o.imm) & MASK;
    else                            enpc = elink;
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      bit done;
      @(negedge clk);
      done = (k == lat + 1);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_alu_en"}, alu_en, fl && !done);
      check({tag, "_mem_re"}, mem_re, ld && k == 1);
      check({tag, "_mem_we"}, mem_we, st && done);
      check({tag, "_npc_valid"}, npc_valid, done);
      check({tag, "_wb_valid"}, wb_valid, done && wb);
      check({tag, "_wb_link"}, wb_link, done && o.jal);
      if (done) begin
        check({tag, "_npc"}, npc, enpc);
        check({tag, "_link_pc"}, link_pc, elink);
        held_npc = enpc;
        held_link = elink;
      end
      if (k == abort_at) begin
        rstn = 1'b0;
        #1;
        held_npc = 0;
        held_link = 0;
        check_idle({tag, "_rst"});
        check({tag, "_rst_mem_re"}, mem_re, 0);
        check({tag, "_rst_wb_link"}, wb_link, 0);
        repeat (3) begin
          @(negedge clk);
          check_idle({tag, "_rst_hold"});
        end
        rstn = 1'b1;
        in_valid = 1'b0;
        return;
      end
      // Garbage on the inputs must not disturb the instruction in flight.
      drive(rand_op(), 1'($urandom));
    end
  endtask

  initial begin
    tb_op_t o;
    #1;
    check_idle("reset");
    check("reset_mem_re", mem_re, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_wb_link", wb_link, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_op("int_add", int_op(5), 0);

    o = int_op(100); o.sorf = 2'b01;
    run_op("float", o, 0);

    o = int_op(200); o.rea = 1;
    run_op("load", o, 0);

    o = int_op(300); o.wea = 1;
    run_op("store", o, 0);

    o = int_op(310); o.rea = 1; o.wea = 1;
    run_op("load_wea", o, 0);

    o = int_op(1020); o.branch = 1; o.cond = 1; o.imm = 10;
    run_op("br_wrap", o, 0);

    o = int_op(1020); o.branch = 1; o.cond = 0; o.imm = 10;
    run_op("br_not", o, 0);

    o = int_op(1023); o.branch = 1; o.cond = 1; o.imm = MASK;
    run_op("br_back", o, 0);

    o = int_op(50); o.jal = 1; o.jr = 1; o.jra = 40; o.jump = 1; o.jt = 77;
    run_op("jal_jr", o, 0);

    o = int_op(60); o.jump = 1; o.jt = 123;
    run_op("jump", o, 0);

    o = int_op(70); o.sorf = 2'b11;
    run_op("sorf_11", o, 0);

    o = int_op(400); o.sorf = 2'b01;
    run_op("fp_abort", o, 2);

    run_op("after_rst", int_op(8), 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        check_idle("gap");
      end
      run_op("rand", rand_op(), 0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
